vga_fb_reader: RTL and testbench

Pixel-fetch stage that consumes the `xvga` timing outputs (`hcount`, `vcount`, `hsync`, `vsync`, `blank`) and turns them into 12-bit VGA colour.

- Reads a scaled framebuffer window from a synchronous-read BRAM, using incrementally maintained addresses (no multiplier).
- Delays sync and blank so they stay aligned with the returned pixel data.
- Sits between `xvga` and the VGA output pins; the framebuffer is filled by the Ethernet receive/decrypt path on its write port.

---
 rtl/vga_fb_reader.sv | 172 +++++++++++++++++
 tb/tb_vga_fb_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: pixel-fetch stage between the xvga timing generator and the
// VGA pins. Reads a scaled framebuffer window from a synchronous-read BRAM and
// realigns hsync/vsync/blank with the returned pixel data.
//
// Ports:
//   vclock, reset           pixel clock, synchronous active-high reset
//   hcount_in, vcount_in    raster position from xvga
//   hsync_in, vsync_in      active-low syncs from xvga
//   blank_in                blanking from xvga
//   fb_addr                 BRAM read address (registered)
//   fb_data                 BRAM read data {r,g,b}, valid RD_LAT cycles after fb_addr
//   vga_r/g/b               registered colour output
//   hsync_out, vsync_out    syncs delayed by RD_LAT+2 cycles
//   blank_out               blank delayed by RD_LAT+2 cycles
//
// VGA_H_TOT / VGA_V_TOT are the xvga line and frame totals; they size the
// count ports.
module vga_fb_reader #(
    parameter int unsigned FB_WIDTH    = 256,
    parameter int unsigned FB_HEIGHT   = 192,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned X0          = 0,
    parameter int unsigned Y0          = 0,
    parameter int unsigned RD_LAT      = 2,
    parameter logic [11:0] BORDER      = 12'h000,
    parameter int unsigned VGA_H_TOT   = 1344,
    parameter int unsigned VGA_V_TOT   = 806,
    localparam int unsigned HW = $clog2(VGA_H_TOT) + 1,
    localparam int unsigned VW = $clog2(VGA_V_TOT) + 1,
    localparam int unsigned AW = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic          vclock,
    input  logic          reset,
    input  logic [HW-1:0] hcount_in,
    input  logic [VW-1:0] vcount_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          blank_in,
    output logic [AW-1:0] fb_addr,
    input  logic [11:0]   fb_data,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          blank_out
);

    localparam int unsigned WIN_W = FB_WIDTH << SCALE_SHIFT;
    localparam int unsigned WIN_H = FB_HEIGHT << SCALE_SHIFT;
    localparam int unsigned L     = RD_LAT + 2;
    localparam int unsigned SW    = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

    localparam logic [HW-1:0] X_LO     = HW'(X0);
    localparam logic [HW-1:0] X_HI     = HW'(X0 + WIN_W);
    localparam logic [HW-1:0] W_LIM    = HW'(WIN_W);
    localparam logic [VW-1:0] Y_LO     = VW'(Y0);
    localparam logic [VW-1:0] H_LIM    = VW'(WIN_H);
    localparam logic [SW-1:0] SUB_MASK = SW'((1 << SCALE_SHIFT) - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(FB_WIDTH);

    logic          frame_ok_q;
    logic          origin, ok, h_in, v_in, in_win;
    logic [HW:0]   h_rel;
    logic [VW:0]   v_rel;

    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] col_q, col_d;
    logic [SW-1:0] line_sub_q, line_sub_d;
    logic [SW-1:0] col_sub_q, col_sub_d;

    logic [L-2:0]  hs_sr_q, vs_sr_q, bl_sr_q, win_sr_q;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs_q, vs_q, bl_q;

    // Window test on offsets from the window origin: the top bit of the
    // widened difference is the borrow, i.e. "position is left of/above X0/Y0".
    always_comb begin
        origin = (hcount_in == '0) && (vcount_in == '0);
        ok     = frame_ok_q | origin;
        h_rel  = {1'b0, hcount_in} - {1'b0, X_LO};
        v_rel  = {1'b0, vcount_in} - {1'b0, Y_LO};
        h_in   = !h_rel[HW] && (h_rel[HW-1:0] < W_LIM);
        v_in   = !v_rel[VW] && (v_rel[VW-1:0] < H_LIM);
        in_win = ok && h_in && v_in;
    end

    // Incremental address generation: col/col_sub walk along the line,
    // row_base/line_sub step down one framebuffer row every 2^S lines.
    always_comb begin
        row_base_d = row_base_q;
        line_sub_d = line_sub_q;
        col_d      = col_q;
        col_sub_d  = col_sub_q;
        if (!ok) begin
            row_base_d = '0;
            line_sub_d = '0;
            col_d      = '0;
            col_sub_d  = '0;
        end else begin
            if (!v_in) begin
                row_base_d = '0;
                line_sub_d = '0;
            end else if (hcount_in == X_HI) begin
                line_sub_d = (line_sub_q + SW'(1)) & SUB_MASK;
                if (line_sub_d == '0)
                    row_base_d = row_base_q + ROW_STEP;
            end
            if (in_win) begin
                if (hcount_in == X_LO) begin
                    col_d     = row_base_q;
                    col_sub_d = SW'(1) & SUB_MASK;
                end else begin
                    // col_sub == 0 here means the previous pixel closed a
                    // 2^S-wide block, so this pixel starts the next column.
                    col_sub_d = (col_sub_q + SW'(1)) & SUB_MASK;
                    if (col_sub_q == '0)
                        col_d = col_q + AW'(1);
                end
            end
        end
    end

    always_comb begin
        rgb_d = BORDER;
        if (bl_sr_q[L-2])
            rgb_d = '0;
        else if (win_sr_q[L-2])
            rgb_d = fb_data;
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            frame_ok_q <= 1'b0;
            row_base_q <= '0;
            line_sub_q <= '0;
            col_q      <= '0;
            col_sub_q  <= '0;
            hs_sr_q    <= '1;
            vs_sr_q    <= '1;
            bl_sr_q    <= '1;
            win_sr_q   <= '0;
            rgb_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            bl_q       <= 1'b1;
        end else begin
            frame_ok_q <= ok;
            row_base_q <= row_base_d;
            line_sub_q <= line_sub_d;
            col_q      <= col_d;
            col_sub_q  <= col_sub_d;
            hs_sr_q    <= {hs_sr_q[L-3:0], hsync_in};
            vs_sr_q    <= {vs_sr_q[L-3:0], vsync_in};
            bl_sr_q    <= {bl_sr_q[L-3:0], blank_in};
            win_sr_q   <= {win_sr_q[L-3:0], in_win};
            rgb_q      <= rgb_d;
            hs_q       <= hs_sr_q[L-2];
            vs_q       <= vs_sr_q[L-2];
            bl_q       <= bl_sr_q[L-2];
        end
    end

    assign fb_addr   = col_q;
    assign vga_r     = rgb_q[11:8];
    assign vga_g     = rgb_q[7:4];
    assign vga_b     = rgb_q[3:0];
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;
    assign blank_out = bl_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: two instances (default window, and a 128x96
// bordered window at (256,192) with BORDER=F00) share one xvga-like stream.
// Each BRAM model returns address[11:0] with a two-cycle read latency.
// Uninteresting lines are driven sparsely (h = 0, 768, 1024) so each line
// still hits both window end columns; selected lines are walked in full.
module tb_vga_fb_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [11:0] h;
    logic [10:0] v;
    logic        hs, vs, bl;

    logic [15:0] addr_a;
    logic [13:0] addr_b;
    logic [11:0] data_a, data_b, a_d1, b_d1;
    logic [3:0]  ra, ga, ba, rb, gb, bb;
    logic        hs_a, vs_a, bl_a, hs_b, vs_b, bl_b;

    int checks   = 0;
    int failures = 0;
    int cur_h    = 0;
    int cur_v    = 0;
    bit fok      = 1'b0;

    typedef struct packed {
        logic [11:0] h;
        logic [10:0] v;
        logic        hs, vs, bl, ok, chk_a;
        logic [11:0] rgb_a, rgb_b;
    } exp_t;

    exp_t hist [4];

    vga_fb_reader u_dut_a (
        .vclock(clk), .reset(rst), .hcount_in(h), .vcount_in(v),
        .hsync_in(hs), .vsync_in(vs), .blank_in(bl),
        .fb_addr(addr_a), .fb_data(data_a),
        .vga_r(ra), .vga_g(ga), .vga_b(ba),
        .hsync_out(hs_a), .vsync_out(vs_a), .blank_out(bl_a)
    );

    vga_fb_reader #(
        .FB_WIDTH(128), .FB_HEIGHT(96), .SCALE_SHIFT(2),
        .X0(256), .Y0(192), .RD_LAT(2), .BORDER(12'hF00)
    ) u_dut_b (
        .vclock(clk), .reset(rst), .hcount_in(h), .vcount_in(v),
        .hsync_in(hs), .vsync_in(vs), .blank_in(bl),
        .fb_addr(addr_b), .fb_data(data_b),
        .vga_r(rb), .vga_g(gb), .vga_b(bb),
        .hsync_out(hs_b), .vsync_out(vs_b), .blank_out(bl_b)
    );

    // BRAM models, read latency 2, contents = address[11:0]
    always @(posedge clk) begin
        a_d1   <= addr_a[11:0];
        data_a <= a_d1;
        b_d1   <= addr_b[11:0];
        data_b <= b_d1;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", tag, cur_h, cur_v, got, exp);
        end
    endtask

    function automatic bit is_full(input int vv);
        return vv inside {0, 9, 192, 195, 196, 300, 575, 579, 767};
    endfunction

    // One pixel clock: drive (hh,vv), advance, then check the address for this
    // sample and the outputs for the sample three steps earlier.
    task automatic step(input int hh, input int vv, input bit do_rst, input bit exact);
        exp_t e;
        int   am, bm;
        bit   in_a, in_b;
        h   = 12'(hh);
        v   = 11'(vv);
        rst = do_rst;
        hs  = (hh >= 1048 && hh < 1184) ? 1'b0 : 1'b1;
        vs  = (vv >= 771 && vv < 777) ? 1'b0 : 1'b1;
        bl  = (hh >= 1024 || vv >= 768);
        if (do_rst) fok = 1'b0;
        else if (hh == 0 && vv == 0) fok = 1'b1;
        in_a = fok && hh < 1024 && vv < 768;
        in_b = fok && hh >= 256 && hh < 768 && vv >= 192 && vv < 576;
        am = (vv / 4) * 256 + (hh / 4);
        bm = in_b ? ((vv - 192) / 4) * 128 + ((hh - 256) / 4) : 0;
        e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.bl = bl; e.ok = fok;
        e.chk_a = exact || !in_a;
        e.rgb_a = bl ? 12'h000 : (in_a ? am[11:0] : 12'h000);
        e.rgb_b = bl ? 12'h000 : (in_b ? bm[11:0] : 12'hF00);
        if (do_rst) begin
            e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b1; e.ok = 1'b0; e.chk_a = 1'b1;
            e.rgb_a = 12'h000; e.rgb_b = 12'h000;
            for (int i = 0; i < 4; i++) hist[i] = e;
        end else begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = e;
        end

        @(posedge clk);
        #1;
        cur_h = hh;
        cur_v = vv;

        check_eq("hsync_a", 16'(hs_a), 16'(hist[3].hs));
        check_eq("vsync_a", 16'(vs_a), 16'(hist[3].vs));
        check_eq("blank_a", 16'(bl_a), 16'(hist[3].bl));
        check_eq("hsync_b", 16'(hs_b), 16'(hist[3].hs));
        check_eq("vsync_b", 16'(vs_b), 16'(hist[3].vs));
        check_eq("blank_b", 16'(bl_b), 16'(hist[3].bl));
        if (hist[3].chk_a)
            check_eq("rgb_a", 16'({ra, ga, ba}), 16'(hist[3].rgb_a));
        check_eq("rgb_b", 16'({rb, gb, bb}), 16'(hist[3].rgb_b));

        if (do_rst || !fok) begin
            check_eq("addr_a_held", addr_a, 16'h0000);
            check_eq("addr_b_held", 16'(addr_b), 16'h0000);
        end else begin
            if (in_a && exact) check_eq("addr_a", addr_a, 16'(am));
            if (in_b)          check_eq("addr_b", 16'(addr_b), 16'(bm));
            if (hh == 5    && vv == 9)   check_eq("spot_addr_a_5_9", addr_a, 16'd513);
            if (hh == 1023 && vv == 767) check_eq("spot_addr_a_last", addr_a, 16'd49151);
            if (hh == 256  && vv == 192) check_eq("spot_addr_b_first", 16'(addr_b), 16'd0);
            if (hh == 256  && vv == 195) check_eq("spot_addr_b_l195", 16'(addr_b), 16'd0);
            if (hh == 256  && vv == 196) check_eq("spot_addr_b_l196", 16'(addr_b), 16'd128);
            if (hh == 767  && vv == 575) check_eq("spot_addr_b_last", 16'(addr_b), 16'd12287);
        end

        if (hist[3].ok) begin
            if (hist[3].h == 5 && hist[3].v == 9)
                check_eq("spot_rgb_a_5_9", 16'({ra, ga, ba}), 16'h0201);
            if (hist[3].h == 255 && hist[3].v == 192)
                check_eq("spot_rgb_b_left", 16'({rb, gb, bb}), 16'h0F00);
            if (hist[3].h == 256 && hist[3].v == 192)
                check_eq("spot_rgb_b_first", 16'({rb, gb, bb}), 16'h0000);
            if (hist[3].h == 768 && hist[3].v == 300)
                check_eq("spot_rgb_b_right", 16'({rb, gb, bb}), 16'h0F00);
            if (hist[3].h == 1100 && hist[3].v == 300)
                check_eq("spot_rgb_b_blank", 16'({rb, gb, bb}), 16'h0000);
            if (hist[3].h == 600 && hist[3].v == 579)
                check_eq("spot_rgb_b_below", 16'({rb, gb, bb}), 16'h0F00);
        end
    endtask

    task automatic run_frame(input bit rst_mid);
        for (int vv = 0; vv < 806; vv++) begin
            if (is_full(vv)) begin
                for (int hh = 0; hh < 1344; hh++)
                    step(hh, vv, rst_mid && vv == 300 && hh >= 400 && hh < 403, 1'b1);
            end else begin
                step(0, vv, 1'b0, 1'b1);
                step(768, vv, 1'b0, 1'b0);
                step(1024, vv, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        h   = '0;
        v   = '0;
        hs  = 1'b1;
        vs  = 1'b1;
        bl  = 1'b1;
        for (int i = 0; i < 3; i++) step(1000, 790, 1'b1, 1'b1);
        run_frame(1'b0);
        run_frame(1'b1);
        run_frame(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
